// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: generator/control-unit requests in, PC redirect and status out.
interface interrupt_controller_if;
    localparam int unsigned PC_W    = 10;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CAUSE_W = 2;

    logic               int_clk;
    logic               int_halt;
    logic [PC_W-1:0]    save_pc;
    logic               int_enable;
    logic               reti;
    logic [SEL_W-1:0]   pc_sel;
    logic [PC_W-1:0]    next_pc;
    logic               stall;
    logic               int_ack;
    logic               in_service;
    logic [CAUSE_W-1:0] cause;
    logic [PC_W-1:0]    epc;

    // Environment side: raises requests, consumes redirects.
    modport master (
        output int_clk, int_halt, save_pc, int_enable, reti,
        input  pc_sel, next_pc, stall, int_ack, in_service, cause, epc
    );

    // Controller side.
    modport slave (
        input  int_clk, int_halt, save_pc, int_enable, reti,
        output pc_sel, next_pc, stall, int_ack, in_service, cause, epc
    );
endinterface

// File: rtl/interrupt_controller.sv
// Two-source (timer/halt) interrupt controller with EPC save/restore.
// Build option: INT_PENDING_QUEUE_EN -- when defined, requests arriving in any
// state are latched and served after RESTORE; otherwise only IDLE latches them.
module interrupt_controller #(
    parameter logic [9:0] TIMER_VECTOR = 10'd1,
    parameter logic [9:0] HALT_VECTOR  = 10'd2
) (
    input logic                   clk,
    input logic                   reset,
    interrupt_controller_if.slave bus
);
    localparam int unsigned PC_W = 10;

    localparam logic [1:0] PC_NORMAL   = 2'b00;
    localparam logic [1:0] PC_VECTOR   = 2'b01;
    localparam logic [1:0] PC_RESTORE  = 2'b10;
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_TIMER = 2'b01;
    localparam logic [1:0] CAUSE_HALT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_SERVICE,
        ST_RESTORE
    } state_t;

    state_t            state_q;
    logic              tpend_q, tpend_d;
    logic              hpend_q, hpend_d;
    logic [PC_W-1:0]   epc_q;
    logic [1:0]        cause_q;
    logic [1:0]        pc_sel_q;
    logic [PC_W-1:0]   next_pc_q;
    logic              stall_q;
    logic              int_ack_q;
    logic              in_service_q;
    logic              set_en;

`ifdef INT_PENDING_QUEUE_EN
    assign set_en = 1'b1;
`else
    assign set_en = (state_q == ST_IDLE);
`endif

    // Pending flags: SAVE clears the served flag, a same-edge request re-sets it.
    always_comb begin
        tpend_d = tpend_q;
        hpend_d = hpend_q;
        if (state_q == ST_SAVE) begin
            if (hpend_q) hpend_d = 1'b0;
            else         tpend_d = 1'b0;
        end
        if (set_en && bus.int_clk)  tpend_d = 1'b1;
        if (set_en && bus.int_halt) hpend_d = 1'b1;
    end

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tpend_q      <= 1'b0;
            hpend_q      <= 1'b0;
            epc_q        <= '0;
            cause_q      <= CAUSE_NONE;
            pc_sel_q     <= PC_NORMAL;
            next_pc_q    <= '0;
            stall_q      <= 1'b0;
            int_ack_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            tpend_q      <= tpend_d;
            hpend_q      <= hpend_d;
            pc_sel_q     <= PC_NORMAL;
            next_pc_q    <= '0;
            stall_q      <= 1'b0;
            int_ack_q    <= 1'b0;
            in_service_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((hpend_q || tpend_q) && bus.int_enable) begin
                        state_q <= ST_SAVE;
                        stall_q <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    state_q   <= ST_VECTOR;
                    epc_q     <= bus.save_pc;
                    cause_q   <= hpend_q ? CAUSE_HALT : CAUSE_TIMER;
                    pc_sel_q  <= PC_VECTOR;
                    next_pc_q <= hpend_q ? HALT_VECTOR : TIMER_VECTOR;
                    int_ack_q <= 1'b1;
                    stall_q   <= 1'b1;
                end
                ST_VECTOR: begin
                    state_q      <= ST_SERVICE;
                    in_service_q <= 1'b1;
                end
                ST_SERVICE: begin
                    in_service_q <= 1'b1;
                    if (bus.reti) begin
                        state_q   <= ST_RESTORE;
                        pc_sel_q  <= PC_RESTORE;
                        next_pc_q <= epc_q;
                        stall_q   <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    state_q <= ST_IDLE;
                    cause_q <= CAUSE_NONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pc_sel     = pc_sel_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.stall      = stall_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.in_service = in_service_q;
    assign bus.cause      = cause_q;
    assign bus.epc        = epc_q;
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter TIMER_VECTOR, default 10'd1: handler address for timer requests.
REQ-002 SHALL have parameter HALT_VECTOR, default 10'd2: handler address for halt requests.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port int_clk, input, 1: timer interrupt request from the interrupt generator.
REQ-006 SHALL have port int_halt, input, 1: halt request from the interrupt generator.
REQ-007 SHALL have port save_pc, input, 10: PC captured by the generator at request time.
REQ-008 SHALL have port int_enable, input, 1: global interrupt enable from control unit.
REQ-009 SHALL have port reti, input, 1: decoded return-from-interrupt instruction.
REQ-010 SHALL have port pc_sel, output, 2: 00 normal PC, 01 vector, 10 restore EPC.
REQ-011 SHALL have port next_pc, output, 10: redirect target, valid when pc_sel != 00, else 0.
REQ-012 SHALL have port stall, output, 1: freeze fetch/pipeline.
REQ-013 SHALL have port int_ack, output, 1: one-cycle acknowledge of a taken request.
REQ-014 SHALL have port in_service, output, 1: handler executing.
REQ-015 SHALL have port cause, output, 2: 00 none, 01 timer, 10 halt.
REQ-016 SHALL have port epc, output, 10: saved return PC.

Function
REQ-017 SHALL keep pending flags tpend/hpend, set at a rising edge where int_clk/int_halt is 1.
REQ-018 SHALL implement FSM IDLE -> SAVE -> VECTOR -> SERVICE -> RESTORE -> IDLE.
REQ-019 IDLE SHALL go to SAVE when (hpend|tpend) and int_enable; else stay; int_enable=0 keeps flags pending.
REQ-020 SAVE (1 cycle) SHALL load epc<=save_pc, cause<=10 if hpend else 01, clear the served flag only, stall=1.
REQ-021 Halt SHALL have priority over timer; when both pending, timer flag remains set and is served after RESTORE.
REQ-022 VECTOR (1 cycle) SHALL drive pc_sel=01, next_pc=HALT_VECTOR or TIMER_VECTOR per cause, int_ack=1, stall=1.
REQ-023 SERVICE SHALL drive in_service=1, stall=0, pc_sel=00; leave on reti=1 to RESTORE.
REQ-024 RESTORE (1 cycle) SHALL drive pc_sel=10, next_pc=epc, stall=1, in_service=1, then IDLE with cause<=00.
REQ-025 reti outside SERVICE SHALL be ignored.
REQ-026 Request set and clear of the same flag in one SAVE cycle: set SHALL win (new request retained).
REQ-027 Latency request-at-edge-N in IDLE with int_enable=1: SAVE at N+1, pc_sel=01 during cycle N+2.
REQ-028 epc SHALL hold its value until the next SAVE; no nesting (requests never preempt SERVICE).

Reset
REQ-029 reset=1 SHALL immediately force IDLE, tpend=hpend=0, epc=0, cause=00, regardless of state.
REQ-030 During/after reset outputs SHALL be pc_sel=00, next_pc=0, stall=0, int_ack=0, in_service=0.

Configuration
REQ-031 Macro INT_PENDING_QUEUE_EN SHALL select pending behaviour.
REQ-032 Defined: requests arriving in any state SHALL set their flag and be served after RESTORE.
REQ-033 Undefined: flags SHALL set only in IDLE; requests in SAVE/VECTOR/SERVICE/RESTORE are dropped.

Verification
REQ-034 Reset, int_clk pulse, save_pc=10'h05A, int_enable=1 -> pc_sel=01, next_pc=1, int_ack=1 two cycles later; epc=05A, cause=01.
REQ-035 In SERVICE, reti=1 -> next cycle pc_sel=10, next_pc=05A, then IDLE, cause=00.
REQ-036 int_clk and int_halt same edge -> halt vectored first (next_pc=2); after reti, timer vectored (next_pc=1).
REQ-037 int_enable=0 with int_clk pulse, enable raised 5 cycles later -> SAVE on next edge, request not lost.
REQ-038 int_clk during SERVICE -> served after RESTORE with INT_PENDING_QUEUE_EN, never served without it.
REQ-039 reset asserted mid-VECTOR -> outputs immediately 0/00, flags cleared, IDLE.
